// File: rtl/async_fifo_wr_packer.sv
// Packs RATIO narrow beats into one FIFO-width word (low lanes first) ahead of the async FIFO write port.
// Optional idle flush of a partial word: define PACKER_TIMEOUT_FLUSH_EN.
module async_fifo_wr_packer #(
    parameter int                  IN_WIDTH       = 8,
    parameter int                  OUT_WIDTH      = 32,
    parameter logic [IN_WIDTH-1:0] PAD            = 8'h00,
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 s_valid,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data,
    input  logic                 m_ready,
    output logic [15:0]          word_cnt
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    localparam logic [0:0] FILL    = 1'b0;
    localparam logic [0:0] PARTIAL = 1'b1;

    if (((OUT_WIDTH % IN_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $error("async_fifo_wr_packer: OUT_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("async_fifo_wr_packer: TIMEOUT_CYCLES must be >= 1");
    end

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic                 m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
    logic [15:0]          word_cnt_q, word_cnt_d;

    logic [0:0]           state;
    logic                 accept;
    logic                 complete_beat;
    logic                 flush;
    logic                 complete;
    logic [OUT_WIDTH-1:0] packed_word;

    // The output register may be refilled in the same cycle it drains.
    assign s_ready       = ~m_valid_q | m_ready;
    assign accept        = s_valid & s_ready;
    assign state         = (cnt_q == '0) ? FILL : PARTIAL;
    assign complete_beat = accept & ((cnt_q == LAST_LANE) | s_last);
    assign complete      = complete_beat | flush;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Fires on the TIMEOUT_CYCLES-th idle cycle; saturates while the output is stalled.
    assign flush = (state == PARTIAL) & ~accept & (idle_q == IDLE_LAST) & s_ready;

    always_comb begin
        idle_d = '0;
        if ((state == PARTIAL) && !accept && !flush) begin
            idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // Lane cnt takes the incoming beat; every lane above the last filled one becomes PAD.
    always_comb begin
        int pad_from;
        packed_word = acc_q;
        pad_from    = int'(cnt_q) + (accept ? 1 : 0);
        for (int i = 0; i < RATIO; i++) begin
            if (accept && (i == int'(cnt_q))) begin
                packed_word[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end else if (i >= pad_from) begin
                packed_word[i*IN_WIDTH +: IN_WIDTH] = PAD;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        case (state)
            FILL: begin
                if (accept) begin
                    if (complete_beat) begin
                        acc_d = '0;
                    end else begin
                        cnt_d = CNT_W'(1);
                        acc_d = packed_word;
                    end
                end
            end
            PARTIAL: begin
                if (complete) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = packed_word;
                end
            end
            default: begin
                cnt_d = '0;
                acc_d = '0;
            end
        endcase
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        word_cnt_d = word_cnt_q;
        if (m_valid_q && m_ready) begin
            m_valid_d  = 1'b0;
            word_cnt_d = word_cnt_q + 16'd1;
        end
        if (complete) begin
            m_valid_d = 1'b1;
            m_data_d  = packed_word;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_async_fifo_wr_packer.sv
// Bench for async_fifo_wr_packer: queue-based beat model checked every cycle plus directed literal checks.
// Honours PACKER_TIMEOUT_FLUSH_EN the same way the design does.
module tb_async_fifo_wr_packer;

    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [15:0] word_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    int stall_cycles = 0;

    logic [7:0]  mdl_beats[$];
    logic        mdl_valid;
    logic [31:0] mdl_data;
    logic [15:0] mdl_cnt;
    int          mdl_idle;
    logic [31:0] captured[$];

    async_fifo_wr_packer #(
        .IN_WIDTH(8),
        .OUT_WIDTH(32),
        .PAD(8'h00),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .word_cnt(word_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] pack_beats();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < RATIO; i++) begin
            w[i*8 +: 8] = (i < mdl_beats.size()) ? mdl_beats[i] : 8'h00;
        end
        return w;
    endfunction

    // Model: a word is the collected beats, padded, emitted when full, on s_last or on idle timeout.
    always @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            mdl_beats.delete();
            mdl_valid = 1'b0;
            mdl_data  = '0;
            mdl_cnt   = '0;
            mdl_idle  = 0;
        end else begin
            logic rdy;
            rdy = !mdl_valid || m_ready;
            if (mdl_valid && m_ready) begin
                mdl_cnt   = mdl_cnt + 16'd1;
                mdl_valid = 1'b0;
            end
            if (s_valid && rdy) begin
                mdl_beats.push_back(s_data);
                mdl_idle = 0;
                if (mdl_beats.size() == RATIO || s_last) begin
                    mdl_data  = pack_beats();
                    mdl_valid = 1'b1;
                    mdl_beats.delete();
                end
            end else if (mdl_beats.size() > 0) begin
                mdl_idle++;
`ifdef PACKER_TIMEOUT_FLUSH_EN
                if (mdl_idle >= TIMEOUT && rdy) begin
                    mdl_data  = pack_beats();
                    mdl_valid = 1'b1;
                    mdl_beats.delete();
                    mdl_idle  = 0;
                end
`endif
            end
        end
    end

    // Per-cycle comparison against the model, plus capture of every word handed to the FIFO.
    always @(negedge wclk) begin
        if (!wrst) begin
            check_output("cyc_s_ready", {31'd0, s_ready}, {31'd0, (!mdl_valid || m_ready)});
            check_output("cyc_m_valid", {31'd0, m_valid}, {31'd0, mdl_valid});
            check_output("cyc_word_cnt", {16'd0, word_cnt}, {16'd0, mdl_cnt});
            if (mdl_valid) begin
                check_output("cyc_m_data", m_data, mdl_data);
            end
            if (m_valid && m_ready) begin
                captured.push_back(m_data);
            end
        end
    end

    task automatic apply_beat(input logic [7:0] d, input logic l);
        int   waited;
        logic took;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        waited  = 0;
        took    = 1'b0;
        while (!took && waited < 50) begin
            @(negedge wclk);
            took = s_ready;
            if (!s_ready) stall_cycles++;
            @(posedge wclk);
            #1;
            waited++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_output("beat_accepted", {31'd0, took}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    initial begin
        int k;
        wrst    = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #2;
        check_output("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_output("rst_m_data", m_data, 32'd0);
        check_output("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check_output("rst_s_ready", {31'd0, s_ready}, 32'd1);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;

        $display("[TB] full frame ending on the last lane");
        apply_beat(8'h11, 1'b0);
        apply_beat(8'h22, 1'b0);
        apply_beat(8'h33, 1'b0);
        apply_beat(8'h44, 1'b1);
        check_output("t1_m_valid", {31'd0, m_valid}, 32'd1);
        check_output("t1_m_data", m_data, 32'h44332211);
        check_output("t1_cnt_before", {16'd0, word_cnt}, 32'd0);
        idle_cycles(1);
        check_output("t1_cnt_after", {16'd0, word_cnt}, 32'd1);
        check_output("t1_drained", {31'd0, m_valid}, 32'd0);

        $display("[TB] short frame padded");
        apply_beat(8'hAA, 1'b0);
        apply_beat(8'hBB, 1'b1);
        check_output("t2_m_data", m_data, 32'h0000BBAA);
        idle_cycles(2);
        check_output("t2_word_cnt", {16'd0, word_cnt}, 32'd2);

        $display("[TB] single-beat frame");
        apply_beat(8'h5A, 1'b1);
        check_output("t2b_m_data", m_data, 32'h0000005A);
        idle_cycles(2);

        $display("[TB] output hold under backpressure");
        m_ready = 1'b0;
        apply_beat(8'h01, 1'b0);
        apply_beat(8'h02, 1'b0);
        apply_beat(8'h03, 1'b0);
        apply_beat(8'h04, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'h05;
        repeat (10) begin
            @(negedge wclk);
            check_output("t3_hold_s_ready", {31'd0, s_ready}, 32'd0);
            check_output("t3_hold_m_data", m_data, 32'h04030201);
        end
        @(posedge wclk);
        #1;
        m_ready = 1'b1;
        apply_beat(8'h05, 1'b0);
        apply_beat(8'h06, 1'b0);
        apply_beat(8'h07, 1'b0);
        apply_beat(8'h08, 1'b1);
        check_output("t3_next_word", m_data, 32'h08070605);
        idle_cycles(2);
        check_output("t3_word_cnt", {16'd0, word_cnt}, 32'd5);

        $display("[TB] continuous stream");
        captured.delete();
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            apply_beat(8'(i), 1'b0);
        end
        idle_cycles(2);
        check_output("t4_stalls", stall_cycles, 32'd0);
        check_output("t4_word_count", captured.size(), 32'd4);
        for (int i = 0; i < 4 && i < captured.size(); i++) begin
            check_output("t4_word", captured[i], 32'h03020100 + 32'(i) * 32'h04040404);
        end

        $display("[TB] reset mid-frame");
        apply_beat(8'hA1, 1'b0);
        apply_beat(8'hA2, 1'b0);
        #2;
        wrst = 1'b1;
        #1;
        check_output("t5_rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check_output("t5_rst_m_valid", {31'd0, m_valid}, 32'd0);
        @(negedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        @(posedge wclk);
        #1;
        captured.delete();
        apply_beat(8'h01, 1'b0);
        apply_beat(8'h02, 1'b0);
        apply_beat(8'h03, 1'b0);
        apply_beat(8'h04, 1'b1);
        idle_cycles(3);
        check_output("t5_words", captured.size(), 32'd1);
        if (captured.size() > 0) check_output("t5_word0", captured[0], 32'h04030201);
        check_output("t5_word_cnt", {16'd0, word_cnt}, 32'd1);

        $display("[TB] idle partial word");
        apply_beat(8'h01, 1'b0);
        apply_beat(8'h02, 1'b0);
        apply_beat(8'h03, 1'b0);
`ifdef PACKER_TIMEOUT_FLUSH_EN
        k = 1;
        while (!m_valid && k < 40) begin
            @(posedge wclk);
            #1;
            k++;
        end
        check_output("t6_flush_latency", k, 32'd17);
        check_output("t6_flush_data", m_data, 32'h00030201);
        idle_cycles(2);
`else
        k = 0;
        repeat (100) begin
            @(posedge wclk);
            #1;
            if (m_valid) k++;
        end
        check_output("t6_no_flush", k, 32'd0);
        apply_beat(8'h04, 1'b1);
        check_output("t6_late_word", m_data, 32'h04030201);
        idle_cycles(2);
`endif
        check_output("t6_word_cnt", {16'd0, word_cnt}, 32'd2);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
